i2s_tx_multilane: RTL and testbench
===================================

// Module: i2s_tx_multilane
// PURPOSE
//  Parametrised I2S master transmitter: N stereo data lanes sharing one MCLK/BCLK/LRCLK.
//  Takes whole frames (all lanes, L+R) over a valid/ready handshake into an internal FIFO.
//  Serialises standard Philips I2S with 32-bit slots. Sits between the lab "top" sound output and board gpio pins.
// PARAMETERS
//  w_sample   16  sample width per channel, 8..32; MSB-first, zero-padded to 32-bit slot
//  n_lanes    1   number of stereo sdata lanes, 1..4
//  bclk_div   8   clk cycles per BCLK half-period; multiple of 4, >=4 (MCLK = 4*BCLK = 256fs)
//  fifo_depth 4   frames buffered; power of 2, >=2
// PORTS
//  clk          in   1                     system clock
//  rst_n        in   1                     synchronous reset, active low
//  in_valid     in   1                     in_data holds a frame
//  in_ready     out  1                     FIFO not full; transfer when in_valid&&in_ready
//  in_data      in   2*n_lanes*w_sample    lane k: {R,L} at [(2k+1)*w_sample +: w_sample], [2k*w_sample +: w_sample]
//  fifo_level   out  $clog2(fifo_depth)+1  frames currently stored
//  underrun     out  1                     sticky: a frame start found FIFO empty
//  underrun_clr in   1                     clears underrun (set wins if same cycle)
//  mclk         out  1                     master clock, clk/(bclk_div/2)
//  bclk         out  1                     bit clock
//  lrclk        out  1                     word select, 0 = left
//  sdata        out  n_lanes               serial data per lane
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): all outputs 0 except in_ready=1; FIFO empty; bit_cnt=63,
//   phase counter 0, shift registers 0, underrun 0. Reset mid-frame abandons the frame immediately.
//  Phase counter 0..2*bclk_div-1 per bit: bclk=0 in first half, 1 in second half; all serial outputs
//   registered, change only at phase 0 (BCLK falling edge). mclk toggles every bclk_div/4 clk cycles, phase-aligned to bit start.
//  bit_cnt 0..63 advances at each phase wrap, 63->0 wraps. lrclk=0 for bit_cnt in {63,0..30}, 1 for {31..62}
//   (WS leads MSB by one bit). Left slot bits 0..31, right slot bits 32..63; sdata[k] = shreg_k[63].
//  Frame start = phase 0 of bit 0: if FIFO non-empty pop one frame into per-lane 64-bit shreg
//   {L,pad,R,pad}; else underrun path (see CONFIGURATION) and underrun<=1.
//  Other bits: shreg shifts left by one at phase 0.
//  FIFO: write on in_valid&&in_ready; pop only at frame start. Simultaneous push+pop when full: push is
//   refused (in_ready=0 that cycle, registered from level). in_ready = (fifo_level < fifo_depth).
//  Pointers wrap modulo fifo_depth; level never exceeds fifo_depth nor goes below 0.
//  First frame after reset: bit 0 occurs 2*bclk_div clk cycles after release (bit 63 runs first, lrclk=0).
//  Frame rate fs = f_clk / (128*bclk_div); e.g. 50 MHz, bclk_div=8 -> 48.828 kHz.
//  Latency: accepted frame's left MSB appears on sdata at the next frame start after all earlier frames.
// CONFIGURATION
//  I2S_TX_UNDERRUN_HOLD_EN defined: on underrun, re-load the last popped frame (0 if none since reset).
//  Not defined: on underrun, load all-zero frame (silence). underrun flag behaves identically in both.
// TESTING
//  1 Reset release, no input: lrclk/bclk periods 128*bclk_div / 2*bclk_div clk cycles, sdata=0, underrun=1 at first bit 0.
//  2 n_lanes=1,w_sample=16: push L=16'hA5F0,R=16'h0F5A -> bits0..15 = A5F0 MSB-first, 16..31=0, 32..47=0F5A, 48..63=0.
//  3 n_lanes=2: lane0 {L=1,R=2}, lane1 {L=16'h8000,R=16'hFFFF} -> each sdata[k] carries its own pair, same bit timing.
//  4 Hold in_valid=1 with no drain: in_ready drops after fifo_depth accepts; fifo_level=fifo_depth; no overwrite.
//  5 Starve after frame X: macro set -> X repeats; unset -> zeros; underrun sticks until underrun_clr pulse.
//  6 Assert rst_n=0 mid right slot: next cycle all outputs 0, fifo_level=0; restart matches scenario 1.

Source files
------------

// File: rtl/i2s_tx_multilane.sv
// Multi-lane Philips I2S master transmitter fed by a frame FIFO over valid/ready.
// Optional I2S_TX_UNDERRUN_HOLD_EN: on underrun repeat the last popped frame instead of silence.
module i2s_tx_multilane #(
  parameter int w_sample   = 16,
  parameter int n_lanes    = 1,
  parameter int bclk_div   = 8,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*n_lanes*w_sample-1:0] in_data,
  output logic [$clog2(fifo_depth):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          mclk,
  output logic                          bclk,
  output logic                          lrclk,
  output logic [n_lanes-1:0]            sdata
);
  localparam int fw = 2*n_lanes*w_sample;
  localparam int pw = $clog2(2*bclk_div);
  localparam int aw = $clog2(fifo_depth);
  localparam int lw = aw + 1;
  localparam int mq = bclk_div / 4;
  localparam int qw = $clog2(mq) + 1;
  localparam logic [pw-1:0] phase_last = pw'(2*bclk_div - 1);
  localparam logic [qw-1:0] mclk_last  = qw'(mq - 1);

  logic [pw-1:0] phase_reg, phase_next;
  logic [5:0]    bit_cnt_reg, bit_cnt_next;
  logic [qw-1:0] mclk_cnt_reg;
  logic          mclk_reg, bclk_reg, lrclk_reg, underrun_reg, in_ready_reg;
  logic [aw-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [lw-1:0] level_reg, level_next;
  logic [fw-1:0] mem [fifo_depth];
  logic [fw-1:0] load_frame;
  logic          phase_wrap, frame_start, push, pop;

  always_comb begin
    phase_wrap   = (phase_reg == phase_last);
    phase_next   = phase_wrap ? '0 : phase_reg + 1'b1;
    bit_cnt_next = phase_wrap ? bit_cnt_reg + 6'd1 : bit_cnt_reg;
    frame_start  = phase_wrap && (bit_cnt_reg == 6'd63);
    push         = in_valid && in_ready_reg;
    pop          = frame_start && (level_reg != '0);
    level_next   = level_reg + lw'(push) - lw'(pop);
  end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [fw-1:0] last_frame_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_frame_reg <= '0;
    end else if (pop) begin
      last_frame_reg <= mem[rd_ptr_reg];
    end
  end

  assign load_frame = pop ? mem[rd_ptr_reg] : last_frame_reg;
`else
  assign load_frame = pop ? mem[rd_ptr_reg] : '0;
`endif

  // Frame storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg    <= '0;
      bit_cnt_reg  <= 6'd63;
      mclk_cnt_reg <= '0;
      mclk_reg     <= 1'b0;
      bclk_reg     <= 1'b0;
      lrclk_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      in_ready_reg <= 1'b1;
      underrun_reg <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      bit_cnt_reg <= bit_cnt_next;
      bclk_reg    <= (phase_next >= pw'(bclk_div));
      // WS switches one bit ahead of each slot's MSB.
      lrclk_reg   <= (bit_cnt_next >= 6'd31) && (bit_cnt_next <= 6'd62);
      if (phase_wrap || (mclk_cnt_reg == mclk_last)) begin
        mclk_cnt_reg <= '0;
      end else begin
        mclk_cnt_reg <= mclk_cnt_reg + 1'b1;
      end
      if (phase_wrap) begin
        mclk_reg <= 1'b0;
      end else if (mclk_cnt_reg == mclk_last) begin
        mclk_reg <= ~mclk_reg;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg    <= level_next;
      in_ready_reg <= (level_next < lw'(fifo_depth));
      if (frame_start && !pop) begin
        underrun_reg <= 1'b1;
      end else if (underrun_clr) begin
        underrun_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < n_lanes; gi++) begin : g_lane
    logic [63:0] shreg_reg;
    logic [31:0] l_slot, r_slot;

    assign l_slot = 32'(load_frame[2*gi*w_sample +: w_sample]) << (32 - w_sample);
    assign r_slot = 32'(load_frame[(2*gi+1)*w_sample +: w_sample]) << (32 - w_sample);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shreg_reg <= '0;
      end else if (frame_start) begin
        shreg_reg <= {l_slot, r_slot};
      end else if (phase_wrap) begin
        shreg_reg <= {shreg_reg[62:0], 1'b0};
      end
    end

    assign sdata[gi] = shreg_reg[63];
  end

  assign in_ready   = in_ready_reg;
  assign fifo_level = level_reg;
  assign underrun   = underrun_reg;
  assign mclk       = mclk_reg;
  assign bclk       = bclk_reg;
  assign lrclk      = lrclk_reg;
endmodule

// File: tb/tb_i2s_tx_multilane.sv
// Scoreboard bench for i2s_tx_multilane: accepted frames queue up, a negedge monitor
// pops them at each frame start and checks clocks, sdata, level, ready and underrun.
module tb_i2s_tx_multilane;
  localparam int W      = 16;
  localparam int NL     = 2;
  localparam int DIV    = 4;
  localparam int DEPTH  = 4;
  localparam int FW     = 2*NL*W;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int BITP   = 2*DIV;
  localparam int FRAMEP = 128*DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic          in_ready, underrun, mclk, bclk, lrclk;
  logic [LW-1:0] fifo_level;
  logic [NL-1:0] sdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [FW-1:0] data;
    int            t_acc;
  } entry_t;

  entry_t        sb_q[$];
  int            t = 0;
  bit            in_rst = 1'b1;
  bit            started = 1'b0;
  bit            clr_s = 1'b0;
  bit            uflag = 1'b0;
  logic [FW-1:0] cur_frame = '0;
  logic [FW-1:0] last_frame = '0;

  i2s_tx_multilane #(
    .w_sample(W), .n_lanes(NL), .bclk_div(DIV), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fifo_level(fifo_level), .underrun(underrun),
    .underrun_clr(underrun_clr), .mclk(mclk), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  // Lane k as it should appear on the wire: {L slot, R slot}, MSB-justified in 32 bits.
  function automatic logic [63:0] slots(input logic [FW-1:0] f, input int k);
    logic [31:0] l, r;
    l = 32'(f[2*k*W +: W]) << (32 - W);
    r = 32'(f[(2*k+1)*W +: W]) << (32 - W);
    return {l, r};
  endfunction

  // Stimulus side of the scoreboard: every accepted frame is queued with its accept time.
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      in_rst = 1'b1;
      t      = 0;
      clr_s  = 1'b0;
      sb_q.delete();
    end else begin
      in_rst = 1'b0;
      t++;
      clr_s = underrun_clr;
      if (in_valid && (sb_q.size() < DEPTH)) begin
        sb_q.push_back('{in_data, t});
        $display("push t=%0d data=%h level=%0d", t, in_data, sb_q.size());
      end
    end
  end

  int            m_ph, m_bn;
  logic [NL-1:0] exp_sd;
  logic [2:0]    exp_clk;
  logic [63:0]   sl;
  entry_t        e;

  always @(negedge clk) begin
    if (started) begin
      if (in_rst) begin
        cur_frame  = '0;
        last_frame = '0;
        uflag      = 1'b0;
        check("reset_outs", 64'({mclk, bclk, lrclk, underrun, sdata, fifo_level, in_ready}), 64'd1);
      end else begin
        m_ph = t % BITP;
        m_bn = (63 + t / BITP) % 64;
        if (t >= BITP && ((t - BITP) % FRAMEP) == 0) begin
          if (sb_q.size() > 0 && sb_q[0].t_acc < t) begin
            e          = sb_q.pop_front();
            cur_frame  = e.data;
            last_frame = e.data;
            $display("frame t=%0d data=%h", t, cur_frame);
          end else begin
            uflag = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            cur_frame = last_frame;
`else
            cur_frame = '0;
`endif
            $display("frame t=%0d underrun data=%h", t, cur_frame);
          end
        end else if (clr_s) begin
          uflag = 1'b0;
        end
        exp_clk = {((m_ph / (DIV/4)) % 2) == 1, m_ph >= DIV, (m_bn >= 31) && (m_bn <= 62)};
        check("clocks", 64'({mclk, bclk, lrclk}), 64'(exp_clk));
        for (int k = 0; k < NL; k++) begin
          sl        = slots(cur_frame, k);
          exp_sd[k] = sl[63 - m_bn];
        end
        check("sdata", 64'(sdata), 64'(exp_sd));
        check("fifo_level", 64'(fifo_level), 64'(sb_q.size()));
        check("in_ready", 64'(in_ready), 64'(sb_q.size() < DEPTH));
        check("underrun", 64'(underrun), 64'(uflag));
      end
    end
  end

  // Return just after the clock edge at the given cycle offset within a frame.
  task automatic sync_to(input int off);
    for (int i = 0; i < 2*FRAMEP + 4; i++) begin
      @(posedge clk);
      #1;
      if (rst_n && t >= BITP && ((t - BITP) % FRAMEP) == off) return;
    end
    checks++;
    errors++;
    $display("FAIL sync_to timeout offset=%0d required within %0d cycles", off, 2*FRAMEP);
  endtask

  task automatic push(input logic [FW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic capture_frame(output logic [63:0] c0, output logic [63:0] c1);
    for (int b = 0; b < 64; b++) begin
      c0[63 - b] = sdata[0];
      c1[63 - b] = sdata[1];
      repeat (BITP) @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] cap0, cap1;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: silence, underrun at the first frame start, then clear it.
    sync_to(100);
    @(negedge clk);
    check("idle_underrun", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    @(negedge clk);
    check("underrun_cleared", 64'(underrun), 64'd0);

    // Two known frames, captured bit by bit at mid-bit.
    sync_to(200);
    push({16'hFFFF, 16'h8000, 16'h0F5A, 16'hA5F0});
    push({16'($urandom), 16'($urandom), 16'h0002, 16'h0001});
    sync_to(DIV);
    capture_frame(cap0, cap1);
    check("frame_a_lane0", cap0, 64'hA5F0_0000_0F5A_0000);
    check("frame_a_lane1", cap1, 64'h8000_0000_FFFF_0000);
    capture_frame(cap0, cap1);
    check("frame_b_lane0", cap0, 64'h0001_0000_0002_0000);

    // Hold in_valid with changing data: FIFO fills and refuses further frames.
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("burst_level", 64'(fifo_level), 64'(DEPTH));
    check("burst_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Random pushes with random gaps while the FIFO drains.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(50, 400)) @(posedge clk);
      #1;
      push({$urandom, $urandom});
    end

    // Starve: last frame repeats or silence, underrun sticks until cleared.
    repeat (3*FRAMEP) @(posedge clk);
    sync_to(100);
    @(negedge clk);
    check("starve_underrun", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    @(negedge clk);
    check("starve_cleared", 64'(underrun), 64'd0);

    // Reset in the middle of the right slot with frames pending.
    sync_to(10*BITP);
    push({$urandom, $urandom});
    push({$urandom, $urandom});
    sync_to(40*BITP + 3);
    check("pre_reset_level", 64'(fifo_level), 64'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_outs", 64'({mclk, bclk, lrclk, underrun, sdata, fifo_level, in_ready}), 64'd1);
    rst_n = 1'b1;
    sync_to(100);
    @(negedge clk);
    check("restart_underrun", 64'(underrun), 64'd1);
    repeat (FRAMEP) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
